// File: rtl/lru_way_age_tracker_if.sv
// rtl/lru_way_age_tracker_if.sv - request/response bundle between the LRU policy and the way age tracker
interface lru_way_age_tracker_if #(
    parameter int NUM_WAYS = 8
);
    localparam int CW = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0]    accessed_way;
    logic                   update_age;
    logic [NUM_WAYS-1:0]    update_done;
    logic                   all_age_update_done;
    logic [NUM_WAYS*CW-1:0] way_age;
    logic [CW-1:0]          accessed_way_age;
    logic [NUM_WAYS-1:0]    expired;
    logic                   eviction_ready;
    logic                   onehot_err;

    modport master (
        output accessed_way,
        output update_age,
        input  update_done,
        input  all_age_update_done,
        input  way_age,
        input  accessed_way_age,
        input  expired,
        input  eviction_ready,
        input  onehot_err
    );

    modport slave (
        input  accessed_way,
        input  update_age,
        output update_done,
        output all_age_update_done,
        output way_age,
        output accessed_way_age,
        output expired,
        output eviction_ready,
        output onehot_err
    );
endinterface

// File: rtl/lru_way_age_tracker.sv
// rtl/lru_way_age_tracker.sv - per-way LRU age counters updated under a request/done handshake
module lru_way_age_tracker #(
    parameter int NUM_WAYS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    lru_way_age_tracker_if.slave  bus
);
    localparam int CW = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_age [NUM_WAYS];
    logic [CW-1:0]          r_acc_idx;
    logic [CW-1:0]          r_acc_age;
    logic [NUM_WAYS-1:0]    r_update_done;
    logic                   r_onehot_err;

    logic                   w_onehot;
    logic [CW-1:0]          w_idx;
    logic                   w_capture;
    logic                   w_reject;
    logic                   w_apply;
    logic                   w_set_done;
    logic                   w_clr_done;
    logic [NUM_WAYS*CW-1:0] w_way_age;
    logic [NUM_WAYS-1:0]    w_expired;
    logic [(1<<CW)-1:0]     w_seen;

    assign w_onehot = (bus.accessed_way != '0) &&
                      ((bus.accessed_way & (bus.accessed_way - NUM_WAYS'(1))) == '0);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (bus.accessed_way[i]) begin
                w_idx = CW'(i);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_reject   = 1'b0;
        w_apply    = 1'b0;
        w_set_done = 1'b0;
        w_clr_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.update_age) begin
                    if (w_onehot) begin
                        w_capture = 1'b1;
                        w_next    = S_UPDATE;
                    end else begin
                        w_reject  = 1'b1;
                    end
                end
            end
            S_UPDATE: begin
                w_apply    = 1'b1;
                w_set_done = 1'b1;
                w_next     = S_DONE;
            end
            S_DONE: begin
                if (!bus.update_age) begin
                    w_clr_done = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Only ways younger than the accessed one age by one, so the ages stay a permutation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_age[i] <= CW'(i);
            end
            r_acc_idx     <= '0;
            r_acc_age     <= '0;
            r_update_done <= '0;
            r_onehot_err  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_acc_idx <= w_idx;
                r_acc_age <= r_age[w_idx];
            end
            if (w_reject) begin
                r_onehot_err <= 1'b1;
            end
            if (w_apply) begin
                for (int j = 0; j < NUM_WAYS; j++) begin
                    if (CW'(j) == r_acc_idx) begin
                        r_age[j] <= '0;
                    end else if (r_age[j] < r_acc_age) begin
                        r_age[j] <= r_age[j] + CW'(1);
                    end
                end
            end
            if (w_set_done) begin
                r_update_done <= '1;
            end else if (w_clr_done) begin
                r_update_done <= '0;
            end
        end
    end

    always_comb begin
        w_way_age = '0;
        w_expired = '0;
        w_seen    = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            w_way_age[k*CW +: CW] = r_age[k];
            w_expired[k]          = (r_age[k] == CW'(NUM_WAYS - 1));
            w_seen[r_age[k]]      = 1'b1;
        end
    end

    assign bus.update_done         = r_update_done;
    assign bus.all_age_update_done = (&r_update_done) & bus.update_age;
    assign bus.way_age             = w_way_age;
    assign bus.accessed_way_age    = r_acc_age;
    assign bus.expired             = w_expired;
    assign bus.eviction_ready      = |w_expired;
    assign bus.onehot_err          = r_onehot_err;

    a_ages_permutation: assert property (@(posedge i_clk) disable iff (i_rst)
        (&w_seen[NUM_WAYS-1:0]));
endmodule

// File: tb/tb_lru_way_age_tracker.sv
// tb/tb_lru_way_age_tracker.sv - directed table plus reference-model checks for lru_way_age_tracker
module tb_lru_way_age_tracker;
    localparam int NW = 4;

    typedef struct {
        logic [3:0] way;
        logic [7:0] ages;
        logic [1:0] acc_age;
        logic [3:0] expired;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [5];
    int   order [$];

    always #5 clk = ~clk;

    lru_way_age_tracker_if #(.NUM_WAYS(NW)) bus ();

    lru_way_age_tracker #(.NUM_WAYS(NW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_request(input logic [3:0] way, input int hold, input logic [3:0] alt_way);
        @(negedge clk);
        bus.accessed_way = way;
        bus.update_age   = 1'b1;
        @(negedge clk);
        check("done_not_yet", 32'(bus.update_done), 32'h0);
        @(negedge clk);
        check("done_set", 32'(bus.update_done), 32'hF);
        check("all_done_set", 32'(bus.all_age_update_done), 32'h1);
        for (int h = 0; h < hold; h++) begin
            bus.accessed_way = alt_way;
            @(negedge clk);
            check("done_held", 32'(bus.update_done), 32'hF);
        end
        bus.update_age = 1'b0;
        #1;
        check("all_done_gated", 32'(bus.all_age_update_done), 32'h0);
        @(negedge clk);
        check("done_cleared", 32'(bus.update_done), 32'h0);
    endtask

    task automatic illegal_request(input logic [3:0] way, input logic [7:0] ages);
        @(negedge clk);
        bus.accessed_way = way;
        bus.update_age   = 1'b1;
        repeat (3) @(negedge clk);
        check("err_set", 32'(bus.onehot_err), 32'h1);
        check("err_no_done", 32'(bus.update_done), 32'h0);
        check("err_ages", 32'(bus.way_age), 32'(ages));
        bus.update_age = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        logic [7:0] exp_ages;
        logic [3:0] seen;
        exp_ages = '0;
        seen     = '0;
        for (int k = 0; k < NW; k++) begin
            exp_ages[order[k]*2 +: 2] = 2'(k);
            seen[bus.way_age[k*2 +: 2]] = 1'b1;
        end
        check(name, 32'(bus.way_age), 32'(exp_ages));
        check("perm", 32'(seen), 32'hF);
    endtask

    initial begin
        vecs[0] = '{way: 4'b0100, ages: 8'hC9, acc_age: 2'd2, expired: 4'b1000};
        vecs[1] = '{way: 4'b1000, ages: 8'h1E, acc_age: 2'd3, expired: 4'b0010};
        vecs[2] = '{way: 4'b1000, ages: 8'h1E, acc_age: 2'd0, expired: 4'b0010};
        vecs[3] = '{way: 4'b0001, ages: 8'h6C, acc_age: 2'd2, expired: 4'b0010};
        vecs[4] = '{way: 4'b0010, ages: 8'hB1, acc_age: 2'd3, expired: 4'b0100};

        rst              = 1'b1;
        bus.accessed_way = '0;
        bus.update_age   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ages", 32'(bus.way_age), 32'hE4);
        check("rst_expired", 32'(bus.expired), 32'h8);
        check("rst_evict", 32'(bus.eviction_ready), 32'h1);
        check("rst_done", 32'(bus.update_done), 32'h0);
        check("rst_acc_age", 32'(bus.accessed_way_age), 32'h0);
        check("rst_err", 32'(bus.onehot_err), 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_request(vecs[v].way, 0, 4'b0000);
            check("vec_ages", 32'(bus.way_age), 32'(vecs[v].ages));
            check("vec_acc_age", 32'(bus.accessed_way_age), 32'(vecs[v].acc_age));
            check("vec_expired", 32'(bus.expired), 32'(vecs[v].expired));
            check("vec_evict", 32'(bus.eviction_ready), 32'h1);
            check("vec_err", 32'(bus.onehot_err), 32'h0);
        end

        illegal_request(4'b0101, 8'hB1);
        illegal_request(4'b0000, 8'hB1);
        check("err_acc_age_kept", 32'(bus.accessed_way_age), 32'h3);

        // Held request with accessed_way wiggling in DONE: only the captured way counts.
        do_request(4'b0100, 3, 4'b0001);
        check("hold_ages", 32'(bus.way_age), 32'hC6);
        check("hold_acc_age", 32'(bus.accessed_way_age), 32'h3);
        check("hold_expired", 32'(bus.expired), 32'h8);
        check("hold_err_sticky", 32'(bus.onehot_err), 32'h1);

        @(negedge clk);
        bus.accessed_way = 4'b0001;
        bus.update_age   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ages", 32'(bus.way_age), 32'hE4);
        check("midrst_done", 32'(bus.update_done), 32'h0);
        check("midrst_err", 32'(bus.onehot_err), 32'h0);
        @(negedge clk);
        bus.update_age = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ages", 32'(bus.way_age), 32'hE4);
        check("postrst_done", 32'(bus.update_done), 32'h0);
        check("postrst_expired", 32'(bus.expired), 32'h8);

        order = '{0, 1, 2, 3};
        for (int r = 0; r < 1000; r++) begin
            int w;
            int pos;
            w   = $urandom_range(0, NW - 1);
            pos = 0;
            for (int k = 0; k < NW; k++) begin
                if (order[k] == w) pos = k;
            end
            order.delete(pos);
            order.push_front(w);
            do_request(4'(1 << w), 0, 4'b0000);
            check_model("rand_ages");
            check("rand_acc_age", 32'(bus.accessed_way_age), 32'(pos));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
